// File: rtl/alu_driver.sv
// rtl/alu_driver.sv - request/response driver for a combinational ALU with settle-delay capture
// Accepts one operation at a time, drives the ALU, captures after SETTLE_CYCLES and holds the response.
module alu_driver #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_a,
  input  logic       req_b,
  input  logic [3:0] req_code,
  input  logic       req_chk,
  input  logic [3:0] req_exp,
  output logic       alu_a,
  output logic       alu_b,
  output logic [3:0] alu_code,
  input  logic [3:0] alu_ans,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [3:0] rsp_ans,
  output logic [3:0] rsp_code,
  output logic       rsp_mismatch,
  output logic       busy,
  output logic [7:0] txn_count,
  output logic [7:0] err_count
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  // Out-of-range settings are clamped so the counter can never start at zero.
  localparam int unsigned SETTLE_EFF =
    (SETTLE_CYCLES < 1) ? 1 : ((SETTLE_CYCLES > 15) ? 15 : SETTLE_CYCLES);
  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_EFF);

  logic [1:0] r_state;
  logic [3:0] r_cnt;
  logic       r_chk;
  logic [3:0] r_exp;
  logic       r_alu_a;
  logic       r_alu_b;
  logic [3:0] r_alu_code;
  logic [3:0] r_rsp_ans;
  logic [3:0] r_rsp_code;
  logic       r_rsp_mm;
  logic [7:0] r_txn;
  logic [7:0] r_err;

  logic w_req_ready;
  logic w_accept;
  logic w_capture;
  logic w_rsp_done;
  logic w_mismatch;

  assign w_req_ready = (r_state == ST_IDLE) && !rst;
  assign w_accept    = req_valid && w_req_ready;
  // Treating a zero count as "last cycle" keeps SETTLE from ever stalling.
  assign w_capture   = (r_state == ST_SETTLE) && (r_cnt <= 4'd1);
  assign w_rsp_done  = (r_state == ST_RESP) && rsp_ready;
  assign w_mismatch  = r_chk && (alu_ans != r_exp);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_chk      <= 1'b0;
      r_exp      <= 4'd0;
      r_alu_a    <= 1'b0;
      r_alu_b    <= 1'b0;
      r_alu_code <= 4'd0;
      r_rsp_ans  <= 4'd0;
      r_rsp_code <= 4'd0;
      r_rsp_mm   <= 1'b0;
      r_txn      <= 8'd0;
      r_err      <= 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_alu_a    <= req_a;
            r_alu_b    <= req_b;
            r_alu_code <= req_code;
            r_chk      <= req_chk;
            r_exp      <= req_exp;
            r_cnt      <= SETTLE_LOAD;
            r_state    <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          r_cnt <= r_cnt - 4'd1;
          if (w_capture) begin
            r_cnt      <= 4'd0;
            r_rsp_ans  <= alu_ans;
            r_rsp_code <= r_alu_code;
            r_rsp_mm   <= w_mismatch;
            r_state    <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (w_rsp_done) begin
            r_txn <= r_txn + 8'd1;
            if (r_rsp_mm && (r_err != 8'hff)) begin
              r_err <= r_err + 8'd1;
            end
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = w_req_ready;
  assign alu_a        = r_alu_a;
  assign alu_b        = r_alu_b;
  assign alu_code     = r_alu_code;
  assign rsp_valid    = (r_state == ST_RESP);
  assign rsp_ans      = r_rsp_ans;
  assign rsp_code     = r_rsp_code;
  assign rsp_mismatch = r_rsp_mm;
  assign busy         = (r_state != ST_IDLE);
  assign txn_count    = r_txn;
  assign err_count    = r_err;

endmodule

// File: tb/tb_alu_driver.sv
// tb/tb_alu_driver.sv - self-checking bench for alu_driver with SETTLE_CYCLES=1 and 3 instances
// Expected values come from plain arithmetic on the operation fields and wrap/saturate counter models.
module tb_alu_driver;

  logic       clk;
  logic       rst;

  logic       req_valid, req_a, req_b, req_chk, rsp_ready;
  logic [3:0] req_code, req_exp, alu_ans;
  logic       req_ready, alu_a, alu_b, rsp_valid, rsp_mismatch, busy;
  logic [3:0] alu_code, rsp_ans, rsp_code;
  logic [7:0] txn_count, err_count;

  logic       req_valid_3, req_a_3, req_b_3, req_chk_3, rsp_ready_3;
  logic [3:0] req_code_3, req_exp_3, alu_ans_3;
  logic       req_ready_3, alu_a_3, alu_b_3, rsp_valid_3, rsp_mismatch_3, busy_3;
  logic [3:0] alu_code_3, rsp_ans_3, rsp_code_3;
  logic [7:0] txn_count_3, err_count_3;

  int n_tests;
  int n_fail;
  int m_txn;
  int m_err;
  int m_txn_3;

  alu_driver #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .req_code(req_code), .req_chk(req_chk), .req_exp(req_exp),
    .alu_a(alu_a), .alu_b(alu_b), .alu_code(alu_code), .alu_ans(alu_ans),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_ans(rsp_ans), .rsp_code(rsp_code),
    .rsp_mismatch(rsp_mismatch), .busy(busy), .txn_count(txn_count), .err_count(err_count)
  );

  alu_driver #(.SETTLE_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid_3), .req_ready(req_ready_3), .req_a(req_a_3), .req_b(req_b_3),
    .req_code(req_code_3), .req_chk(req_chk_3), .req_exp(req_exp_3),
    .alu_a(alu_a_3), .alu_b(alu_b_3), .alu_code(alu_code_3), .alu_ans(alu_ans_3),
    .rsp_valid(rsp_valid_3), .rsp_ready(rsp_ready_3), .rsp_ans(rsp_ans_3), .rsp_code(rsp_code_3),
    .rsp_mismatch(rsp_mismatch_3), .busy(busy_3), .txn_count(txn_count_3), .err_count(err_count_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full operation on the SETTLE_CYCLES=1 instance, with rsp_ready held off for 'delay' cycles.
  task automatic do_op(input logic a, input logic b, input logic [3:0] code, input logic ce,
                       input logic [3:0] ex, input logic [3:0] ans, input int delay);
    logic mm;
    mm = ce && (ans != ex);
    req_valid = 1'b1; req_a = a; req_b = b; req_code = code; req_chk = ce; req_exp = ex;
    rsp_ready = 1'b0;
    chk("op_req_ready", req_ready, 1);
    step();
    req_valid = 1'b0;
    req_a = 1'($urandom); req_b = 1'($urandom); req_code = 4'($urandom);
    req_chk = 1'($urandom); req_exp = 4'($urandom);
    chk("op_settle_valid", rsp_valid, 0);
    chk("op_settle_busy", busy, 1);
    chk("op_alu_a", alu_a, a);
    chk("op_alu_b", alu_b, b);
    chk("op_alu_code", alu_code, code);
    alu_ans = ans;
    step();
    alu_ans = 4'($urandom);
    chk("op_rsp_valid", rsp_valid, 1);
    chk("op_rsp_ans", rsp_ans, ans);
    chk("op_rsp_code", rsp_code, code);
    chk("op_rsp_mm", rsp_mismatch, mm);
    for (int i = 0; i < delay; i++) begin
      step();
      chk("op_hold_valid", rsp_valid, 1);
      chk("op_hold_ans", rsp_ans, ans);
      chk("op_hold_mm", rsp_mismatch, mm);
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    m_txn = (m_txn + 1) % 256;
    if (mm && m_err < 255) m_err++;
    chk("op_done_busy", busy, 0);
    chk("op_done_ready", req_ready, 1);
    chk("op_txn", txn_count, m_txn);
    chk("op_err", err_count, m_err);
    chk("op_alu_hold", alu_code, code);
  endtask

  // One operation on the SETTLE_CYCLES=3 instance; alu_ans moves from 'first' to 'fin' after one cycle.
  task automatic do_op3(input logic a, input logic b, input logic [3:0] code, input logic ce,
                        input logic [3:0] ex, input logic [3:0] first, input logic [3:0] fin);
    req_valid_3 = 1'b1; req_a_3 = a; req_b_3 = b; req_code_3 = code;
    req_chk_3 = ce; req_exp_3 = ex; rsp_ready_3 = 1'b0;
    alu_ans_3 = first;
    chk("op3_req_ready", req_ready_3, 1);
    step();
    req_valid_3 = 1'b0;
    chk("op3_valid_n0", rsp_valid_3, 0);
    step();
    alu_ans_3 = fin;
    chk("op3_valid_n1", rsp_valid_3, 0);
    step();
    chk("op3_valid_n2", rsp_valid_3, 0);
    step();
    alu_ans_3 = 4'($urandom);
    chk("op3_valid_n3", rsp_valid_3, 1);
    chk("op3_rsp_ans", rsp_ans_3, fin);
    chk("op3_rsp_code", rsp_code_3, code);
    chk("op3_rsp_mm", rsp_mismatch_3, ce && (fin != ex));
    rsp_ready_3 = 1'b1;
    step();
    rsp_ready_3 = 1'b0;
    m_txn_3 = (m_txn_3 + 1) % 256;
    chk("op3_busy", busy_3, 0);
    chk("op3_txn", txn_count_3, m_txn_3);
  endtask

  initial begin
    logic [3:0] ex;
    logic [3:0] an;
    n_tests = 0; n_fail = 0; m_txn = 0; m_err = 0; m_txn_3 = 0;
    rst = 1'b1;
    req_valid = 0; req_a = 0; req_b = 0; req_code = 0; req_chk = 0; req_exp = 0;
    alu_ans = 0; rsp_ready = 0;
    req_valid_3 = 0; req_a_3 = 0; req_b_3 = 0; req_code_3 = 0; req_chk_3 = 0; req_exp_3 = 0;
    alu_ans_3 = 0; rsp_ready_3 = 0;
    step();
    step();
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_alu", {alu_a, alu_b, alu_code}, 0);
    chk("rst_rsp", {rsp_ans, rsp_code, rsp_mismatch}, 0);
    chk("rst_counts", {txn_count, err_count}, 0);
    rst = 1'b0;
    step();
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_busy", busy, 0);

    // Basic operation, latency 1.
    do_op(1'b1, 1'b1, 4'h1, 1'b0, 4'h0, 4'h2, 0);
    chk("basic_txn", txn_count, 1);

    // Latency 3 with alu_ans changing 3 -> 7 after acceptance.
    do_op3(1'b1, 1'b0, 4'h6, 1'b0, 4'h0, 4'h3, 4'h7);

    // Mismatch counting and req_chk masking.
    do_op(1'b0, 1'b1, 4'h5, 1'b1, 4'h1, 4'h0, 0);
    chk("mm_err1", err_count, 1);
    do_op(1'b0, 1'b1, 4'h5, 1'b1, 4'h1, 4'h1, 0);
    chk("mm_err_stays", err_count, 1);
    do_op(1'b1, 1'b0, 4'h3, 1'b0, 4'h8, 4'h2, 1);
    chk("nochk_err", err_count, 1);

    // Backpressure with a new request pending; no acceptance on the handshake edge.
    req_valid = 1'b1; req_a = 1'b1; req_b = 1'b0; req_code = 4'h9; req_chk = 1'b0;
    step();
    req_a = 1'b0; req_b = 1'b1; req_code = 4'h4; alu_ans = 4'hc;
    step();
    chk("bp_capture", rsp_ans, 4'hc);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_req_ready", req_ready, 0);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rsp", {rsp_ans, rsp_code, rsp_mismatch}, {4'hc, 4'h9, 1'b0});
      chk("bp_alu", {alu_a, alu_b, alu_code}, {1'b1, 1'b0, 4'h9});
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    m_txn++;
    chk("bp_idle", busy, 0);
    chk("bp_no_accept", alu_code, 4'h9);
    chk("bp_txn", txn_count, m_txn);
    step();
    req_valid = 1'b0;
    chk("bp_next_busy", busy, 1);
    chk("bp_next_alu", {alu_a, alu_b, alu_code}, {1'b0, 1'b1, 4'h4});
    alu_ans = 4'h3;
    step();
    chk("bp_next_ans", rsp_ans, 4'h3);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    m_txn++;
    chk("bp_next_txn", txn_count, m_txn);

    // Randomized operations on both instances.
    for (int i = 0; i < 40; i++) begin
      ex = 4'($urandom);
      an = ($urandom_range(0, 1) == 0) ? ex : 4'($urandom);
      do_op(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), ex, an, $urandom_range(0, 3));
    end
    for (int i = 0; i < 8; i++) begin
      do_op3(1'($urandom), 1'($urandom), 4'($urandom), 1'($urandom), 4'($urandom),
             4'($urandom), 4'($urandom));
    end

    // Reset in the middle of SETTLE abandons the operation.
    req_valid = 1'b1; req_a = 1'b1; req_b = 1'b0; req_code = 4'h7; req_chk = 1'b1; req_exp = 4'h0;
    alu_ans = 4'h5;
    step();
    req_valid = 1'b0;
    chk("midrst_busy", busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_txn = 0; m_err = 0; m_txn_3 = 0;
    chk("midrst_valid", rsp_valid, 0);
    chk("midrst_outs", {alu_a, alu_b, alu_code, rsp_ans, rsp_code, rsp_mismatch, busy}, 0);
    chk("midrst_counts", {txn_count, err_count}, 0);
    step();
    chk("midrst_after_valid", rsp_valid, 0);
    chk("midrst_after_txn", txn_count, 0);
    chk("midrst_after_ready", req_ready, 1);

    // 256 mismatching checked operations: txn wraps, err saturates.
    for (int i = 0; i < 256; i++) begin
      ex = 4'($urandom);
      an = ex ^ 4'($urandom_range(1, 15));
      do_op(1'($urandom), 1'($urandom), 4'($urandom), 1'b1, ex, an, 0);
      if (i == 254) chk("wrap_err_255", err_count, 255);
    end
    chk("wrap_txn", txn_count, 0);
    chk("wrap_err_sat", err_count, 255);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
